noc_bridge_vc_rx: RTL and testbench

//   Receive side of the credit-based virtual-channel NoC bridge. Accepts axis_packet_t beats from the link.

---
 rtl/noc_bridge_pkg.sv | 44 ++++
 rtl/noc_bridge_rx_chan.sv | 85 ++++++++
 rtl/noc_bridge_vc_rx.sv | 135 +++++++++++++
 tb/tb_noc_bridge_vc_rx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_bridge_pkg.sv
// Shared types for the credit-based virtual-channel NoC bridge.
// Link beat layout: tdata = {data_hdr, data}, tuser = {data_validity, credits_hdr, credits}.
package noc_bridge_pkg;

    localparam int unsigned NumCredNocBridge = 8;

    typedef enum logic {
        CH_RSP = 1'b0,
        CH_REQ = 1'b1
    } channel_hdr_e;

    typedef logic [$clog2(NumCredNocBridge+1)-1:0] bridge_credit_t;

    typedef logic [39:0] flit_req_data_t;
    typedef logic [31:0] flit_rsp_data_t;

    // Link data field is sized for the wider of the two channel payloads
    localparam int unsigned FlitDataW = ($bits(flit_req_data_t) > $bits(flit_rsp_data_t)) ?
                                        $bits(flit_req_data_t) : $bits(flit_rsp_data_t);

    typedef struct packed {
        channel_hdr_e         data_hdr;
        logic [FlitDataW-1:0] data;
    } data_bits_t;

    typedef struct packed {
        logic           data_validity;
        channel_hdr_e   credits_hdr;
        bridge_credit_t credits;
    } user_bit_t;

    typedef struct packed {
        data_bits_t tdata;
        user_bit_t  tuser;
    } axis_packet_t;

    localparam logic [0:0] IdxReq = 1'b0;
    localparam logic [0:0] IdxRsp = 1'b1;

    function automatic logic [0:0] hdr_to_idx(channel_hdr_e hdr);
        return (hdr == CH_REQ) ? IdxReq : IdxRsp;
    endfunction

endpackage

// File: rtl/noc_bridge_rx_chan.sv
// One receive channel: registered FIFO (no fall-through) plus the count of
// popped slots not yet handed back to the remote end as credits.
module noc_bridge_rx_chan #(
    parameter int unsigned DataW = 32,
    parameter int unsigned Depth = 8,
    parameter int unsigned CredW = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [DataW-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [DataW-1:0] data_o,
    input  logic             ret_ack_i,
    output logic [CredW-1:0] ret_cnt_o,
    output logic             drop_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [DataW-1:0] mem_q [Depth];
    logic [DataW-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [CredW-1:0] ret_q, ret_d;
    logic             full, pop, wr_en;

    function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full      = (cnt_q == CntW'(Depth));
    assign valid_o   = (cnt_q != '0);
    assign data_o    = mem_q[rd_ptr_q];
    assign pop       = valid_o && ready_i;
    // When full, a same-cycle pop frees the slot being overwritten
    assign wr_en     = push_i && (!full || pop);
    assign drop_o    = push_i && full && !pop;
    assign ret_cnt_o = ret_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        ret_d = ret_ack_i ? '0 : ret_q;
        if (pop && (ret_d != CredW'(Depth))) begin
            ret_d = ret_d + CredW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ret_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ret_q    <= ret_d;
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/noc_bridge_vc_rx.sv
// Receive side of the virtual-channel NoC bridge: link demux, credit-in register.
// Optional NOC_BRIDGE_RX_OVF_ERR_EN adds a sticky ovf_err_o for dropped overflow flits.
module noc_bridge_vc_rx
    import noc_bridge_pkg::*;
#(
    parameter int unsigned NumCred  = NumCredNocBridge,
    parameter int unsigned ReqDataW = $bits(flit_req_data_t),
    parameter int unsigned RspDataW = $bits(flit_rsp_data_t)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [$bits(data_bits_t)-1:0]  axis_tdata_i,
    input  logic [$bits(user_bit_t)-1:0]   axis_tuser_i,
    input  logic                           axis_tvalid_i,
    output logic                           axis_tready_o,
    output logic                           req_valid_o,
    input  logic                           req_ready_i,
    output logic [ReqDataW-1:0]            req_data_o,
    output logic                           rsp_valid_o,
    input  logic                           rsp_ready_i,
    output logic [RspDataW-1:0]            rsp_data_o,
    output logic                           cred_in_valid_o,
    output logic                           cred_in_hdr_o,
    output logic [$bits(bridge_credit_t)-1:0] cred_in_o,
    output logic [$bits(bridge_credit_t)-1:0] cred_ret_req_o,
    output logic [$bits(bridge_credit_t)-1:0] cred_ret_rsp_o,
    input  logic                           cred_ret_ack_i,
    input  logic                           cred_ret_hdr_i
`ifdef NOC_BRIDGE_RX_OVF_ERR_EN
    ,
    output logic                           ovf_err_o
`endif
);

    localparam int unsigned CredW = $bits(bridge_credit_t);

    data_bits_t     tdata;
    user_bit_t      tuser;
    logic           accept;
    logic [1:0]     push;
    logic [1:0]     ack;
    logic [1:0]     drop;
    logic           ready_q, ready_d;
    logic           cred_vld_q, cred_vld_d;
    channel_hdr_e   cred_hdr_q, cred_hdr_d;
    bridge_credit_t cred_q, cred_d;

    assign tdata  = data_bits_t'(axis_tdata_i);
    assign tuser  = user_bit_t'(axis_tuser_i);
    assign accept = axis_tvalid_i && ready_q;

    always_comb begin
        push = '0;
        if (accept && tuser.data_validity) begin
            push[hdr_to_idx(tdata.data_hdr)] = 1'b1;
        end
        ack = '0;
        if (cred_ret_ack_i) begin
            ack[hdr_to_idx(channel_hdr_e'(cred_ret_hdr_i))] = 1'b1;
        end
        ready_d    = 1'b1;
        cred_vld_d = accept && (tuser.credits != '0);
        cred_hdr_d = cred_hdr_q;
        cred_d     = cred_q;
        if (cred_vld_d) begin
            cred_hdr_d = tuser.credits_hdr;
            cred_d     = tuser.credits;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ready_q    <= 1'b0;
            cred_vld_q <= 1'b0;
            cred_hdr_q <= CH_RSP;
            cred_q     <= '0;
        end else begin
            ready_q    <= ready_d;
            cred_vld_q <= cred_vld_d;
            cred_hdr_q <= cred_hdr_d;
            cred_q     <= cred_d;
        end
    end

    assign axis_tready_o   = ready_q;
    assign cred_in_valid_o = cred_vld_q;
    assign cred_in_hdr_o   = cred_hdr_q;
    assign cred_in_o       = cred_q;

    noc_bridge_rx_chan #(.DataW(ReqDataW), .Depth(NumCred), .CredW(CredW)) u_req_chan (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push[IdxReq]),
        .data_i    (tdata.data[ReqDataW-1:0]),
        .valid_o   (req_valid_o),
        .ready_i   (req_ready_i),
        .data_o    (req_data_o),
        .ret_ack_i (ack[IdxReq]),
        .ret_cnt_o (cred_ret_req_o),
        .drop_o    (drop[IdxReq])
    );

    noc_bridge_rx_chan #(.DataW(RspDataW), .Depth(NumCred), .CredW(CredW)) u_rsp_chan (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (push[IdxRsp]),
        .data_i    (tdata.data[RspDataW-1:0]),
        .valid_o   (rsp_valid_o),
        .ready_i   (rsp_ready_i),
        .data_o    (rsp_data_o),
        .ret_ack_i (ack[IdxRsp]),
        .ret_cnt_o (cred_ret_rsp_o),
        .drop_o    (drop[IdxRsp])
    );

`ifdef NOC_BRIDGE_RX_OVF_ERR_EN
    logic ovf_q, ovf_d;

    assign ovf_d = ovf_q || (drop != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_err_o = ovf_q;
`else
    logic unused_drop;
    assign unused_drop = ^drop;
`endif

endmodule

// File: tb/tb_noc_bridge_vc_rx.sv
// Directed bench for noc_bridge_vc_rx; ovf_err_o is checked when NOC_BRIDGE_RX_OVF_ERR_EN is defined.
module tb_noc_bridge_vc_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [40:0] axis_tdata = '0;
    logic [5:0]  axis_tuser = '0;
    logic        axis_tvalid = 1'b0;
    logic        axis_tready;
    logic        req_valid, rsp_valid;
    logic        req_ready = 1'b0, rsp_ready = 1'b0;
    logic [39:0] req_data;
    logic [31:0] rsp_data;
    logic        cred_in_valid, cred_in_hdr;
    logic [3:0]  cred_in, cred_ret_req, cred_ret_rsp;
    logic        cred_ret_ack = 1'b0, cred_ret_hdr = 1'b0;
`ifdef NOC_BRIDGE_RX_OVF_ERR_EN
    logic        ovf_err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    noc_bridge_vc_rx dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .axis_tdata_i    (axis_tdata),
        .axis_tuser_i    (axis_tuser),
        .axis_tvalid_i   (axis_tvalid),
        .axis_tready_o   (axis_tready),
        .req_valid_o     (req_valid),
        .req_ready_i     (req_ready),
        .req_data_o      (req_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_data_o      (rsp_data),
        .cred_in_valid_o (cred_in_valid),
        .cred_in_hdr_o   (cred_in_hdr),
        .cred_in_o       (cred_in),
        .cred_ret_req_o  (cred_ret_req),
        .cred_ret_rsp_o  (cred_ret_rsp),
        .cred_ret_ack_i  (cred_ret_ack),
        .cred_ret_hdr_i  (cred_ret_hdr)
`ifdef NOC_BRIDGE_RX_OVF_ERR_EN
        ,
        .ovf_err_o       (ovf_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic hdr, input logic vld, input logic [39:0] d,
                        input logic crhdr, input logic [3:0] cr);
        axis_tdata  = {hdr, d};
        axis_tuser  = {vld, crhdr, cr};
        axis_tvalid = 1'b1;
    endtask

    task automatic idle();
        axis_tvalid = 1'b0;
        axis_tuser  = '0;
    endtask

    task automatic ack_chan(input logic hdr);
        cred_ret_ack = 1'b1;
        cred_ret_hdr = hdr;
        step();
        cred_ret_ack = 1'b0;
    endtask

    logic [39:0] qreq[$];
    logic [31:0] qrsp[$];

    initial begin
        // Reset values
        step();
        step();
        chk("rst_tready", axis_tready, 0);
        chk("rst_req_vld", req_valid, 0);
        chk("rst_rsp_vld", rsp_valid, 0);
        chk("rst_cred_vld", cred_in_valid, 0);
        chk("rst_cred_hdr", cred_in_hdr, 0);
        chk("rst_cred", cred_in, 0);
        chk("rst_ret_req", cred_ret_req, 0);
        chk("rst_ret_rsp", cred_ret_rsp, 0);
`ifdef NOC_BRIDGE_RX_OVF_ERR_EN
        chk("rst_ovf", ovf_err, 0);
`endif
        rst_n = 1'b1;
        chk("tready_low_at_release", axis_tready, 0);
        step();
        chk("tready_after_release", axis_tready, 1);

        // 1: single request flit, then pop
        beat(1'b1, 1'b1, 40'h12_3456_789A, 1'b0, 4'd0);
        step();
        idle();
        chk("t1_req_vld", req_valid, 1);
        chk("t1_req_data", req_data, 40'h12_3456_789A);
        chk("t1_no_cred", cred_in_valid, 0);
        chk("t1_ret0", cred_ret_req, 0);
        chk("t1_rsp_vld", rsp_valid, 0);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("t1_popped", req_valid, 0);
        chk("t1_ret1", cred_ret_req, 1);
        ack_chan(1'b1);
        chk("t1_ack_clear", cred_ret_req, 0);

        // 2: fill to depth, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            beat(1'b1, 1'b1, 40'hA0_0000_0000 + 40'(i), 1'b0, 4'd0);
            step();
        end
        beat(1'b1, 1'b1, 40'hDE_ADDE_ADDE, 1'b0, 4'd0);
        chk("t2_full_head", req_data, 40'hA0_0000_0000);
`ifdef NOC_BRIDGE_RX_OVF_ERR_EN
        chk("t2_ovf_before", ovf_err, 0);
`endif
        step();
        idle();
`ifdef NOC_BRIDGE_RX_OVF_ERR_EN
        chk("t2_ovf_after", ovf_err, 1);
`endif
        req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain_vld", req_valid, 1);
            chk("t2_drain_data", req_data, 40'hA0_0000_0000 + 40'(i));
            step();
        end
        req_ready = 1'b0;
        chk("t2_empty_after_drain", req_valid, 0);
        chk("t2_ret8", cred_ret_req, 8);
`ifdef NOC_BRIDGE_RX_OVF_ERR_EN
        chk("t2_ovf_sticky", ovf_err, 1);
`endif
        ack_chan(1'b1);
        chk("t2_ack_clear", cred_ret_req, 0);

        // 3: credit-only beat, then data beat carrying request credits
        beat(1'b1, 1'b0, 40'hFF_FFFF_FFFF, 1'b0, 4'd5);
        step();
        idle();
        chk("t3_cred_vld", cred_in_valid, 1);
        chk("t3_cred_hdr", cred_in_hdr, 0);
        chk("t3_cred", cred_in, 5);
        chk("t3_no_push", req_valid, 0);
        step();
        chk("t3_cred_pulse_end", cred_in_valid, 0);
        beat(1'b0, 1'b1, 40'h11_2233_4455, 1'b1, 4'd3);
        step();
        idle();
        chk("t3b_cred_vld", cred_in_valid, 1);
        chk("t3b_cred_hdr", cred_in_hdr, 1);
        chk("t3b_cred", cred_in, 3);
        chk("t3b_rsp_vld", rsp_valid, 1);
        chk("t3b_rsp_data", rsp_data, 32'h2233_4455);
        chk("t3b_req_vld", req_valid, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("t3b_rsp_popped", rsp_valid, 0);
        chk("t3b_ret_rsp", cred_ret_rsp, 1);

        // 4: ack together with a pop leaves a count of 1
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 1'b1, 40'hB0_0000_0000 + 40'(i), 1'b0, 4'd0);
            step();
        end
        idle();
        req_ready = 1'b1;
        step();
        step();
        step();
        chk("t4_ret3", cred_ret_req, 3);
        chk("t4_head", req_data, 40'hB0_0000_0003);
        cred_ret_ack = 1'b1;
        cred_ret_hdr = 1'b1;
        step();
        cred_ret_ack = 1'b0;
        req_ready = 1'b0;
        chk("t4_ack_pop", cred_ret_req, 1);
        chk("t4_rsp_unaffected", cred_ret_rsp, 1);
        chk("t4_empty", req_valid, 0);

        // 5: interleaved channels with random ready against a queue model
        for (int i = 0; i < 60; i++) begin
            logic rr, sr, hdr, room;
            logic [39:0] d;
            rr = 1'($urandom_range(0, 1));
            sr = 1'($urandom_range(0, 1));
            req_ready = rr;
            rsp_ready = sr;
            chk("t5_req_vld", req_valid, qreq.size() != 0);
            chk("t5_rsp_vld", rsp_valid, qrsp.size() != 0);
            if (rr && qreq.size() > 0) begin
                chk("t5_req_data", req_data, qreq.pop_front());
            end
            if (sr && qrsp.size() > 0) begin
                chk("t5_rsp_data", rsp_data, qrsp.pop_front());
            end
            hdr  = (i % 3) != 0;
            room = hdr ? (qreq.size() < 8) : (qrsp.size() < 8);
            d    = 40'hC0_0000_0000 + 40'(i) * 40'h0_0101_0101;
            if (room) begin
                beat(hdr, 1'b1, d, 1'b0, 4'd0);
                if (hdr) qreq.push_back(d);
                else     qrsp.push_back(d[31:0]);
            end else begin
                idle();
            end
            step();
        end
        idle();
        req_ready = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t5d_req_vld", req_valid, qreq.size() != 0);
            chk("t5d_rsp_vld", rsp_valid, qrsp.size() != 0);
            if (qreq.size() > 0) chk("t5d_req_data", req_data, qreq.pop_front());
            if (qrsp.size() > 0) chk("t5d_rsp_data", rsp_data, qrsp.pop_front());
            step();
        end
        req_ready = 1'b0;
        rsp_ready = 1'b0;
        chk("t5_req_drained", req_valid, 0);
        chk("t5_rsp_drained", rsp_valid, 0);

        // 6: reset with both buffers half full
        for (int i = 0; i < 8; i++) begin
            beat(i[0], 1'b1, 40'hE0_0000_0000 + 40'(i), 1'b0, 4'd0);
            step();
        end
        idle();
        chk("t6_req_vld_pre", req_valid, 1);
        chk("t6_rsp_vld_pre", rsp_valid, 1);
        rst_n = 1'b0;
        step();
        chk("t6_req_vld", req_valid, 0);
        chk("t6_rsp_vld", rsp_valid, 0);
        chk("t6_ret_req", cred_ret_req, 0);
        chk("t6_ret_rsp", cred_ret_rsp, 0);
        chk("t6_tready", axis_tready, 0);
        chk("t6_cred_hdr", cred_in_hdr, 0);
`ifdef NOC_BRIDGE_RX_OVF_ERR_EN
        chk("t6_ovf", ovf_err, 0);
`endif
        rst_n = 1'b1;
        chk("t6_tready_release", axis_tready, 0);
        step();
        chk("t6_tready_up", axis_tready, 1);
        chk("t6_still_empty", req_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
